// File: rtl/div_iter.sv
// div_iter: iterative 32-bit integer divider for the E stage (DIV / DIVU).
//
// One restoring shift-subtract step per clock on a 64-bit partial remainder
// {remainder, dividend/quotient}. Operands are reduced to magnitudes at
// acceptance and the latched sign flags restore the signs when the last
// step completes.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   start_i      DIV/DIVU in E requests a result
//   signed_i     1 = DIV (two's complement), 0 = DIVU
//   a_i, b_i     dividend, divisor (32 bit)
//   flush_i      exception flush of E; aborts everything at the next edge
//   mem_stall_i  cache stall; holds a finished result in DONE
//   div_stall_o  E-stage stall request (combinational)
//   valid_o      quot_o / rem_o valid for the current E instruction
//   quot_o       quotient (LO)
//   rem_o        remainder (HI)
//
// Configuration
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iteration:
//                     IDLE goes straight to DONE with quot_o = 0xFFFFFFFF
//                     and rem_o = a_i. Undefined: zero divisor takes the
//                     normal 33-cycle path with unspecified result values.
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on acceptance
// BUSY  | one shift-subtract step per cycle, 32 steps
// DONE  | result valid; held while mem_stall_i is high

module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        mem_stall_i,
  output logic        div_stall_o,
  output logic        valid_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT       state;
  logic [5:0]  iterCnt;
  logic [63:0] partRem;
  logic [31:0] divisor;
  logic        quotNeg;
  logic        remNeg;
  logic        validReg;
  logic [31:0] quotReg;
  logic [31:0] remReg;

  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [32:0] trial;
  logic [31:0] diff;
  logic        fits;
  logic [63:0] partRemNext;
  logic [31:0] quotFinal;
  logic [31:0] remFinal;

  assign aMag = (signed_i & a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign bMag = (signed_i & b_i[31]) ? (~b_i + 32'd1) : b_i;

  // The shifted remainder needs 33 bits (it can reach 2*divisor-1). When the
  // subtraction succeeds the result is below the divisor, so the low 32 bits
  // of the modular difference are exact.
  always_comb begin
    trial       = partRem[63:31];
    fits        = (trial >= {1'b0, divisor});
    diff        = trial[31:0] - divisor;
    partRemNext = fits ? {diff, partRem[30:0], 1'b1}
                       : {trial[31:0], partRem[30:0], 1'b0};
    // Negating 0x80000000 wraps back to itself, which gives the required
    // 0x80000000 / -1 result without a special case.
    quotFinal   = quotNeg ? (~partRemNext[31:0] + 32'd1) : partRemNext[31:0];
    remFinal    = remNeg  ? (~partRemNext[63:32] + 32'd1) : partRemNext[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      iterCnt  <= 6'd0;
      partRem  <= 64'd0;
      divisor  <= 32'd0;
      quotNeg  <= 1'b0;
      remNeg   <= 1'b0;
      validReg <= 1'b0;
      quotReg  <= 32'd0;
      remReg   <= 32'd0;
    end else if (flush_i) begin
      state    <= IDLE;
      validReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            partRem <= {32'd0, aMag};
            divisor <= bMag;
            quotNeg <= (a_i[31] ^ b_i[31]) & signed_i;
            remNeg  <= a_i[31] & signed_i;
            iterCnt <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
            if (b_i == 32'd0) begin
              state    <= DONE;
              validReg <= 1'b1;
              quotReg  <= 32'hFFFF_FFFF;
              remReg   <= a_i;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          partRem <= partRemNext;
          iterCnt <= iterCnt + 6'd1;
          if (iterCnt == 6'd31) begin
            state    <= DONE;
            validReg <= 1'b1;
            quotReg  <= quotFinal;
            remReg   <= remFinal;
          end
        end
        DONE: begin
          if (!mem_stall_i) begin
            state    <= IDLE;
            validReg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          validReg <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst so a start_i held across reset cannot raise a stall.
  assign div_stall_o = ~rst & ~flush_i &
                       (((state == IDLE) & start_i) | (state == BUSY));
  assign valid_o     = validReg;
  assign quot_o      = quotReg;
  assign rem_o       = remReg;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        mem_stall_i;
  logic        div_stall_o;
  logic        valid_o;
  logic [31:0] quot_o;
  logic [31:0] rem_o;

  int checkCnt = 0;
  int passCnt  = 0;

  div_iter dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .mem_stall_i (mem_stall_i),
    .div_stall_o (div_stall_o),
    .valid_o     (valid_o),
    .quot_o      (quot_o),
    .rem_o       (rem_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one divide at a negedge, count stall cycles, then hold the result
  // with mem_stall_i for 'hold' cycles and confirm the return to IDLE.
  task automatic doDiv(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input int expStall, input logic chkVals,
                       input logic [31:0] expQ, input logic [31:0] expR,
                       input int hold, input logic keepStart);
    int stallCnt;
    int validCnt;
    stallCnt = 0;
    @(negedge clk);
    rst      = 1'b0;
    start_i  = 1'b1;
    signed_i = sgn;
    a_i      = a;
    b_i      = b;
    #1;
    while (div_stall_o && stallCnt < 100) begin
      stallCnt++;
      @(negedge clk);
      start_i = keepStart;
      if (keepStart) begin
        a_i = 32'h0000_0042;
        b_i = 32'h0000_0003;
      end
      #1;
    end
    start_i = 1'b0;
    check({tag, ":stallCycles"}, stallCnt, expStall);
    check({tag, ":validRise"}, {31'd0, valid_o}, 32'd1);
    if (chkVals) begin
      check({tag, ":quot"}, quot_o, expQ);
      check({tag, ":rem"}, rem_o, expR);
    end
    validCnt = 1;
    while (validCnt < 20) begin
      mem_stall_i = (validCnt <= hold);
      @(negedge clk);
      #1;
      if (!valid_o) break;
      validCnt++;
      if (chkVals && validCnt == hold + 1) begin
        check({tag, ":quotHeld"}, quot_o, expQ);
        check({tag, ":remHeld"}, rem_o, expR);
      end
    end
    mem_stall_i = 1'b0;
    check({tag, ":validCycles"}, validCnt, hold + 1);
    check({tag, ":idleStall"}, {31'd0, div_stall_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seenValid;
    rst         = 1'b1;
    start_i     = 1'b1;
    signed_i    = 1'b0;
    a_i         = 32'd100;
    b_i         = 32'd7;
    flush_i     = 1'b0;
    mem_stall_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset:stall", {31'd0, div_stall_o}, 32'd0);
    check("reset:valid", {31'd0, valid_o}, 32'd0);
    check("reset:quot", quot_o, 32'd0);
    check("reset:rem", rem_o, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    doDiv("divu100by7", 1'b0, 32'd100, 32'd7, 33, 1'b1, 32'd14, 32'd2, 0, 1'b0);
    doDiv("divNeg100by7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 1'b0);
    doDiv("div100byNeg7", 1'b1, 32'd100, 32'hFFFF_FFF9, 33, 1'b1, 32'hFFFF_FFF2, 32'd2, 0, 1'b0);
    doDiv("divMinByNeg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, 32'h8000_0000, 32'd0, 0, 1'b0);
    doDiv("divuBigByAllOnes", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, 32'd0, 32'h8000_0000, 0, 1'b0);
    doDiv("divuMaxBy1Hold", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 1'b1, 32'hFFFF_FFFF, 32'd0, 5, 1'b0);
    doDiv("startIgnoredBusy", 1'b0, 32'd1000, 32'd7, 33, 1'b1, 32'd142, 32'd6, 0, 1'b1);

    // Flush in the tenth BUSY cycle.
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'h0000_1000;
    b_i      = 32'd3;
    repeat (10) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #1;
    check("flush:busyStall", {31'd0, div_stall_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush:stallMasked", {31'd0, div_stall_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush:idleStall", {31'd0, div_stall_o}, 32'd0);
    seenValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid_o) seenValid = 1'b1;
    end
    check("flush:neverValid", {31'd0, seenValid}, 32'd0);

    // Flush together with start in IDLE must not start anything.
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("flushStart:stall", {31'd0, div_stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check("flushStart:noBusy", {31'd0, div_stall_o}, 32'd0);

    doDiv("divu9by3", 1'b0, 32'd9, 32'd3, 33, 1'b1, 32'd3, 32'd0, 0, 1'b0);

    // Reset in the twentieth BUSY cycle, start_i held across release.
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd1000;
    b_i      = 32'd10;
    repeat (20) @(negedge clk);
    a_i = 32'd100;
    b_i = 32'd7;
    rst = 1'b1;
    #1;
    check("rstBusy:stall", {31'd0, div_stall_o}, 32'd0);
    check("rstBusy:valid", {31'd0, valid_o}, 32'd0);
    check("rstBusy:quot", quot_o, 32'd0);
    check("rstBusy:rem", rem_o, 32'd0);
    @(negedge clk);
    #1;
    check("rstHeld:stall", {31'd0, div_stall_o}, 32'd0);
    doDiv("afterRst100by7", 1'b0, 32'd100, 32'd7, 33, 1'b1, 32'd14, 32'd2, 0, 1'b0);

`ifdef DIV_ZERO_FAST_EN
    doDiv("divu5by0", 1'b0, 32'd5, 32'd0, 1, 1'b1, 32'hFFFF_FFFF, 32'd5, 0, 1'b0);
`else
    doDiv("divu5by0", 1'b0, 32'd5, 32'd0, 33, 1'b0, 32'd0, 32'd0, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start_i, input, 1: a DIV/DIVU is in the E stage and requests a result.
REQ-004 SHALL have port signed_i, input, 1: 1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have port a_i, input, 32: dividend, E-stage operand.
REQ-006 SHALL have port b_i, input, 32: divisor, E-stage operand.
REQ-007 SHALL have port flush_i, input, 1: exception flush of E (flush_exceptionM).
REQ-008 SHALL have port mem_stall_i, input, 1: cache stall (i_cache_stall | d_cache_stall); holds a finished result.
REQ-009 SHALL have port div_stall_o, output, 1: E-stage stall request to the hazard unit (drives alu_stallE).
REQ-010 SHALL have port valid_o, output, 1: quot_o/rem_o are valid for the current E instruction.
REQ-011 SHALL have port quot_o, output, 32: quotient, written to LO.
REQ-012 SHALL have port rem_o, output, 32: remainder, written to HI.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE.
REQ-014 IDLE: if start_i & ~flush_i, SHALL latch |a_i|, |b_i|, quotient sign (a[31]^b[31])&signed_i, remainder sign a[31]&signed_i, clear iteration counter, go BUSY.
REQ-015 BUSY: SHALL perform one restoring shift-subtract step per cycle on a 64-bit partial remainder with a 6-bit counter; after step 32 SHALL go DONE.
REQ-016 DONE: SHALL hold valid_o=1 and stable results while mem_stall_i=1; with mem_stall_i=0 SHALL return to IDLE next edge.
REQ-017 div_stall_o SHALL be combinational: ~flush_i & ((IDLE & start_i) | BUSY); 0 in DONE.
REQ-018 Latency: accept cycle plus 32 BUSY cycles, so div_stall_o is high for exactly 33 cycles and valid_o rises in cycle 33.
REQ-019 A start_i seen while in BUSY or DONE SHALL be ignored; no new operation until IDLE.
REQ-020 Sign correction SHALL negate quotient/remainder magnitude when the corresponding latched sign is 1.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quot 0x80000000, rem 0x00000000.
REQ-022 flush_i in any state SHALL force IDLE at the next edge, discard results, deassert valid_o; flush_i with start_i in IDLE SHALL NOT start.
REQ-023 Divisor zero without REQ-029 SHALL keep 33-cycle timing; result values unspecified.
REQ-024 quot_o/rem_o SHALL be don't-care when valid_o=0.

Reset
REQ-025 rst SHALL force IDLE, counter 0, partial remainder 0, sign flags 0.
REQ-026 During/after reset div_stall_o=0, valid_o=0, quot_o=0, rem_o=0.
REQ-027 rst mid-BUSY SHALL abort the operation; no result appears after release.

Configuration
REQ-028 Macro DIV_ZERO_FAST_EN SHALL select divide-by-zero handling.
REQ-029 With DIV_ZERO_FAST_EN defined: b_i==0 at acceptance SHALL go IDLE->DONE directly, div_stall_o high only in the accept cycle, quot_o=0xFFFFFFFF, rem_o=a_i unchanged.
REQ-030 Without DIV_ZERO_FAST_EN: zero divisor SHALL follow normal BUSY path (REQ-023).

Verification
REQ-031 DIVU 100/7, no stalls -> div_stall_o high 33 cycles; valid_o, quot 14, rem 2.
REQ-032 DIV -100/7 -> quot 0xFFFFFFF2 (-14), rem 0xFFFFFFFE (-2); DIV 0x80000000/0xFFFFFFFF -> quot 0x80000000, rem 0.
REQ-033 DIVU 0xFFFFFFFF/1, mem_stall_i high 5 cycles from DONE entry -> valid_o held 6 cycles, quot 0xFFFFFFFF, rem 0, then IDLE.
REQ-034 flush_i at BUSY cycle 10 -> next cycle IDLE, div_stall_o 0, valid_o never asserted; new DIVU 9/3 then gives quot 3, rem 0.
REQ-035 rst pulse at BUSY cycle 20 -> all outputs 0; start_i held through reset release -> fresh 33-cycle operation.
REQ-036 DIVU 5/0 with DIV_ZERO_FAST_EN -> div_stall_o 1 cycle, quot 0xFFFFFFFF, rem 5; without macro -> 33-cycle stall.
